// File: rtl/adc_channel_averager.sv
// Per-channel boxcar averager: accumulates 2^AVG_LOG2 samples per mux channel
// and emits one truncated average tagged with the channel address.

module adc_avg_chan #(
    parameter int ACC_W = 14,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr,
    input  logic [ACC_W-1:0] acc_nxt,
    input  logic [CNT_W-1:0] cnt_nxt,
    output logic [ACC_W-1:0] acc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear) begin
            acc <= '0;
            cnt <= '0;
        end else if (wr) begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
        end
    end
endmodule

module adc_channel_averager #(
    parameter int DATA_W   = 12,
    parameter int AVG_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [DATA_W-1:0] inData,
    input  logic              inValid,
    input  logic [4:0]        inAddress,
    output logic [DATA_W-1:0] outData,
    output logic              outValid,
    output logic [4:0]        outAddress,
    output logic              overrun
);
    localparam int NUM_CH = 32;
    localparam int ACC_W  = DATA_W + AVG_LOG2;
    // With AVG_LOG2=0 the counter is a constant-zero bit that synthesis removes.
    localparam int CNT_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << AVG_LOG2) - 1);

    logic [NUM_CH-1:0][ACC_W-1:0] acc_q;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;

    logic [ACC_W-1:0] acc_sel;
    logic [CNT_W-1:0] cnt_sel;
    logic [ACC_W:0]   sum;
    logic             take;
    logic             last;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // One shared adder; only the addressed channel is read and written back.
    always_comb begin
        acc_sel = acc_q[inAddress];
        cnt_sel = cnt_q[inAddress];
        sum     = {1'b0, acc_sel} + {{(AVG_LOG2 + 1){1'b0}}, inData};
        take    = inValid & ~clear;
        last    = (cnt_sel == CNT_MAX);
        acc_nxt = last ? '0 : sum[ACC_W-1:0];
        cnt_nxt = last ? '0 : cnt_sel + CNT_W'(1);
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        adc_avg_chan #(
            .ACC_W (ACC_W),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .clear   (clear),
            .wr      (take && (inAddress == 5'(c))),
            .acc_nxt (acc_nxt),
            .cnt_nxt (cnt_nxt),
            .acc     (acc_q[c]),
            .cnt     (cnt_q[c])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outData    <= '0;
            outValid   <= 1'b0;
            outAddress <= '0;
            overrun    <= 1'b0;
        end else begin
            outValid <= 1'b0;
            if (take) begin
                if (last) begin
                    outValid   <= 1'b1;
                    outData    <= sum[ACC_W-1:AVG_LOG2];
                    outAddress <= inAddress;
                end
                if (sum[ACC_W])
                    overrun <= 1'b1;
            end
        end
    end
endmodule

// File: doc/adc_channel_averager.md
# adc_channel_averager

Per-channel boxcar averager between the ADC SPI receiver and the analog distributor. Each 12-bit sample, tagged with a 5-bit mux channel address, is added to a per-channel accumulator. After 2^AVG_LOG2 samples on a channel, the block emits one averaged word with that channel's address and restarts accumulation. The goal is to suppress ADC noise on the telemetry analog channels without changing the distributor's valid/address handshake.

## Interface
Parameters:
- DATA_W, 12, sample and output data width
- AVG_LOG2, 2, log2 of samples per average; legal 0..4; 0 = pass-through with 1-cycle latency

Ports:
- clk  input  1  system clock (80 MHz domain, same as ADC receiver)
- reset  input  1  asynchronous, active-low reset
- clear  input  1  synchronous; zero all accumulators and sample counters
- inData  input  DATA_W  sample from ADC receiver
- inValid  input  1  one-cycle strobe; inData/inAddress valid
- inAddress  input  5  channel index 0..31 of current sample
- outData  output  DATA_W  averaged sample
- outValid  output  1  one-cycle strobe; outData/outAddress valid
- outAddress  output  5  channel index of outData
- overrun  output  1  sticky; set if an accumulator would exceed its width (cannot happen for legal AVG_LOG2; sanity flag)

## Operation
- State per channel c (0..31): acc[c], DATA_W+AVG_LOG2 bits; cnt[c], AVG_LOG2 bits (absent when AVG_LOG2=0).
- Single registered update stage; no ready/backpressure. Every inValid is accepted.
- On a clk edge with inValid=1 and clear=0, let a=inAddress and sum = acc[a] + inData, computed at full DATA_W+AVG_LOG2 width.
  - If cnt[a] == 2^AVG_LOG2-1: outData <= sum[DATA_W+AVG_LOG2-1:AVG_LOG2] (truncating divide, no rounding); outAddress <= a; outValid <= 1; acc[a] <= 0; cnt[a] <= 0.
  - Otherwise: acc[a] <= sum; cnt[a] <= cnt[a]+1; outValid <= 0.
- Other channels are untouched. Channel interleaving is arbitrary; each channel completes independently.
- On an edge with inValid=0: outValid <= 0. outData and outAddress hold their last values.
- clear=1: all acc and cnt go to 0, and outValid <= 0.
  - clear has priority over a simultaneous inValid; that sample is discarded.
  - outData, outAddress and overrun are unchanged.
- overrun: set if a carry out of the accumulator MSB would occur. Cleared only by reset.
- AVG_LOG2=0: every valid sample is output unchanged one cycle later.

## Timing
- Reset (reset=0, asynchronous): acc=0, cnt=0, outData=0, outValid=0, outAddress=0, overrun=0. Release is synchronous to clk at the next edge.
- Latency: outValid is high for exactly the one cycle following the edge that captured the completing sample.
- Back-to-back inValid on consecutive cycles is allowed, including on the same channel. Each read-modify-write completes in one edge, so there is no hazard and no sample is lost.
- Maximum throughput is one sample per clk. outValid can assert on consecutive cycles.
- Reset asserted mid-accumulation discards all partial sums. The first average after release uses 2^AVG_LOG2 fresh samples.
- The outputs drive the distributor directly. The outValid strobe is the same one-cycle pulse format as the SPI receiver's spiReady.

## Test plan
- Reset/idle: hold reset=0, then release with no inValid for 100 cycles -> outValid stays 0, outData=0, outAddress=0, overrun=0.
- Single-channel average, AVG_LOG2=2: inAddress=3 with samples 100, 200, 300, 401 on non-consecutive cycles -> exactly one outValid, one cycle after the 4th sample, with outData=250 (1001>>2, truncated), outAddress=3. A further 4 samples of 4095 on channel 3 -> outData=4095, overrun=0.
- Interleaving, AVG_LOG2=2: alternate channels 0 and 31 on every cycle, channel 0 = 8 and channel 31 = 12, for 8 samples total -> outValid on the cycles after samples 7 and 8 (two consecutive pulses): (0,8) then (31,12). No other pulses.
- Back-to-back same channel: 8 consecutive cycles of inValid on channel 5 with data 0,1,...,7 -> outData=1 (6>>2) then outData=5 (22>>2), each with outAddress=5.
- clear collision: on channel 7, 3 samples of 1000, then a 4th sample with clear=1 on the same edge -> no outValid. Then 4 samples of 40 -> outData=40.
- Async reset mid-operation, and pass-through: assert reset for half a cycle after 2 samples on channel 2 -> all state is zero, and the next average needs 4 fresh samples. With AVG_LOG2=0: input 0xABC on channel 9 -> outData=0xABC, outAddress=9 one cycle later.
